// File: rtl/requant_pipe.sv
// requant_pipe: three-stage per-channel requantizer.
// Stage 1 multiplies the accumulator by a Q(MULT_W-1) channel multiplier,
// stage 2 applies a rounding arithmetic right shift, stage 3 adds the
// channel zero point and saturates to OUT_W signed. All stages advance
// together under a single enable/backpressure condition.
module requant_pipe #(
    parameter  int IN_W    = 64,
    parameter  int OUT_W   = 8,
    parameter  int MULT_W  = 32,
    parameter  int SHIFT_W = 5,
    parameter  int NCH     = 4,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_W-1:0]    in_data,
    input  logic        [CH_W-1:0]    in_ch,
    input  logic                      cfg_we,
    input  logic        [CH_W-1:0]    cfg_ch,
    input  logic signed [MULT_W-1:0]  cfg_mult,
    input  logic        [SHIFT_W-1:0] cfg_shift,
    input  logic signed [OUT_W-1:0]   cfg_zp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic        [CH_W-1:0]    out_ch,
    output logic                      out_sat
);

    localparam int PW = IN_W + MULT_W;
    localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);
    localparam logic signed [PW-1:0] ONE = PW'(1);
    localparam logic signed [PW:0] QMAX = (PW + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PW:0] QMIN = (PW + 1)'(-(2 ** (OUT_W - 1)));

    // Per-channel configuration table
    logic signed [MULT_W-1:0]  mult_q  [NCH];
    logic        [SHIFT_W-1:0] shift_q [NCH];
    logic signed [OUT_W-1:0]   zp_q    [NCH];

    // Pipeline registers
    logic                      v1_q, v2_q, v3_q;
    logic        [CH_W-1:0]    ch1_q, ch2_q, ch3_q;
    logic signed [PW-1:0]      prod1_q;
    logic        [SHIFT_W-1:0] shift1_q;
    logic signed [OUT_W-1:0]   zp1_q, zp2_q;
    logic signed [PW-1:0]      r2_q;
    logic signed [OUT_W-1:0]   q3_q;
    logic                      sat3_q;

    // Next-state values
    logic                      adv;
    logic                      cfg_ok;
    logic                      in_ch_ok;
    logic signed [MULT_W-1:0]  mult_sel;
    logic        [SHIFT_W-1:0] shift_sel;
    logic signed [OUT_W-1:0]   zp_sel;
    logic signed [PW-1:0]      prod_d;
    logic        [31:0]        sh_amt;
    logic signed [PW-1:0]      rnd;
    logic signed [PW-1:0]      r_d;
    logic signed [PW:0]        sum;
    logic signed [OUT_W-1:0]   q_d;
    logic                      sat_d;

    assign adv      = en & (~v3_q | out_ready);
    assign in_ready = adv;
    assign cfg_ok   = cfg_we && ({1'b0, cfg_ch} < NCH_L);
    assign in_ch_ok = {1'b0, in_ch} < NCH_L;

    assign out_valid = v3_q;
    assign out_data  = q3_q;
    assign out_ch    = ch3_q;
    assign out_sat   = sat3_q;

    // Table write port; independent of en so config can load while frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                mult_q[i]  <= '0;
                shift_q[i] <= '0;
                zp_q[i]    <= '0;
            end
        end else if (cfg_ok) begin
            mult_q[cfg_ch]  <= cfg_mult;
            shift_q[cfg_ch] <= cfg_shift;
            zp_q[cfg_ch]    <= cfg_zp;
        end
    end

    // Table lookup and multiply; out-of-range channels read as all-zero
    always_comb begin
        mult_sel  = '0;
        shift_sel = '0;
        zp_sel    = '0;
        if (in_ch_ok) begin
            mult_sel  = mult_q[in_ch];
            shift_sel = shift_q[in_ch];
            zp_sel    = zp_q[in_ch];
        end
        prod_d = PW'(in_data) * PW'(mult_sel);
    end

    // Rounding right shift by MULT_W-1+shift (half rounds toward +inf)
    always_comb begin
        sh_amt = 32'(MULT_W - 1) + 32'(shift1_q);
        rnd    = ONE <<< (sh_amt - 32'd1);
        r_d    = (prod1_q + rnd) >>> sh_amt;
    end

    // Zero-point add and saturation to the signed output range
    always_comb begin
        sum   = (PW + 1)'(r2_q) + (PW + 1)'(zp2_q);
        q_d   = sum[OUT_W-1:0];
        sat_d = 1'b0;
        if (sum > QMAX) begin
            q_d   = {1'b0, {(OUT_W - 1){1'b1}}};
            sat_d = 1'b1;
        end else if (sum < QMIN) begin
            q_d   = {1'b1, {(OUT_W - 1){1'b0}}};
            sat_d = 1'b1;
        end
    end

    // Lock-step pipeline advance; everything holds when adv is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            ch1_q    <= '0;
            ch2_q    <= '0;
            ch3_q    <= '0;
            prod1_q  <= '0;
            shift1_q <= '0;
            zp1_q    <= '0;
            zp2_q    <= '0;
            r2_q     <= '0;
            q3_q     <= '0;
            sat3_q   <= 1'b0;
        end else if (adv) begin
            v1_q     <= in_valid;
            ch1_q    <= in_ch;
            prod1_q  <= prod_d;
            shift1_q <= shift_sel;
            zp1_q    <= zp_sel;

            v2_q     <= v1_q;
            ch2_q    <= ch1_q;
            r2_q     <= r_d;
            zp2_q    <= zp1_q;

            v3_q     <= v2_q;
            ch3_q    <= ch2_q;
            q3_q     <= q_d;
            sat3_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_requant_pipe.sv
// Scoreboard bench for requant_pipe: expected results are queued at input
// acceptance and compared in order when the output handshake completes.
module tb_requant_pipe;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [63:0] in_data = '0;
    logic        [1:0]  in_ch = '0;
    logic               cfg_we = 1'b0;
    logic        [1:0]  cfg_ch = '0;
    logic signed [31:0] cfg_mult = '0;
    logic        [4:0]  cfg_shift = '0;
    logic signed [7:0]  cfg_zp = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [7:0]  out_data;
    logic        [1:0]  out_ch;
    logic               out_sat;

    int checks = 0;
    int errors = 0;
    int rx_count = 0;

    typedef struct {
        logic signed [7:0] data;
        logic [1:0]        ch;
        logic              sat;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic signed [31:0] m_mult  [4];
    logic        [4:0]  m_shift [4];
    logic signed [7:0]  m_zp    [4];

    logic               prev_hold = 1'b0;
    logic signed [7:0]  h_data;
    logic [1:0]         h_ch;
    logic               h_sat;

    requant_pipe #(
        .IN_W(64), .OUT_W(8), .MULT_W(32), .SHIFT_W(5), .NCH(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .cfg_zp(cfg_zp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // Output monitor: in-order scoreboard compare and stall-hold check
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== h_data || out_ch !== h_ch ||
                    out_sat !== h_sat) begin
                    errors++;
                    $display("FAIL hold: got v=%0b d=%0d ch=%0d sat=%0b, need v=1 d=%0d ch=%0d sat=%0b",
                             out_valid, out_data, out_ch, out_sat, h_data, h_ch, h_sat);
                end
            end
            if (out_valid && out_ready && en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got d=%0d ch=%0d, need no output",
                             out_data, out_ch);
                end else begin
                    e = sb.pop_front();
                    rx_count++;
                    if (out_data !== e.data || out_ch !== e.ch || out_sat !== e.sat) begin
                        errors++;
                        $display("FAIL result: got d=%0d ch=%0d sat=%0b, need d=%0d ch=%0d sat=%0b",
                                 out_data, out_ch, out_sat, e.data, e.ch, e.sat);
                    end
                end
            end
            prev_hold = out_valid && !(en && out_ready);
            h_data = out_data;
            h_ch   = out_ch;
            h_sat  = out_sat;
        end
    end

    function automatic void model(input logic signed [63:0] d, input logic [1:0] ch,
                                  output logic signed [7:0] q, output logic sat);
        logic signed [127:0] p, m, t, r;
        int s;
        p = d;
        m = m_mult[ch];
        p = p * m;
        s = 31 + int'(m_shift[ch]);
        t = 128'sd1 <<< (s - 1);
        r = (p + t) >>> s;
        r = r + 128'(m_zp[ch]);
        sat = 1'b0;
        if (r > 127) begin
            q = 8'sd127; sat = 1'b1;
        end else if (r < -128) begin
            q = -8'sd128; sat = 1'b1;
        end else begin
            q = r[7:0];
        end
    endfunction

    task automatic cfg_write(input logic [1:0] ch, input int mult, input int shift, input int zp);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_mult  = 32'(mult);
        cfg_shift = 5'(shift);
        cfg_zp    = 8'(zp);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_mult[ch]  = 32'(mult);
        m_shift[ch] = 5'(shift);
        m_zp[ch]    = 8'(zp);
    endtask

    task automatic send(input logic signed [63:0] d, input logic [1:0] ch,
                        input logic signed [7:0] exp_d, input logic exp_sat);
        exp_t x;
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_ch    = ch;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) begin
                x.data = exp_d; x.ch = ch; x.sat = exp_sat;
                sb.push_back(x);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 30 cycles, need acceptance");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic signed [63:0] d, input logic [1:0] ch);
        logic signed [7:0] q;
        logic s;
        model(d, ch, q, s);
        send(d, ch, q, s);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, need 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b need 0", out_valid); end
        checks++;
        if (out_data !== 8'sd0) begin errors++; $display("FAIL reset_data: got %0d need 0", out_data); end
        checks++;
        if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d need 0", out_ch); end
        checks++;
        if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b need 0", out_sat); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_mult[i] = '0; m_shift[i] = '0; m_zp[i] = '0;
        end
    endtask

    task automatic test_basic();
        cfg_write(2'd0, 1 << 30, 7, 0);
        send(64'sd8179, 2'd0, 8'sd32, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got out_valid=%0b need 0", out_valid); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_3: got out_valid=%0b need 1", out_valid); end
        drain();
        send(-64'sd998, 2'd0, -8'sd4, 1'b0);
        drain();
        cfg_write(2'd0, 1 << 30, 7, 10);
        send(64'sd8179, 2'd0, 8'sd42, 1'b0);
        drain();
    endtask

    task automatic test_saturate();
        cfg_write(2'd1, 1 << 30, 0, 0);
        send(64'sd1 <<< 20, 2'd1, 8'sd127, 1'b1);
        send(-(64'sd1 <<< 20), 2'd1, -8'sd128, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        int base;
        logic signed [63:0] d0 [4];
        logic signed [63:0] d1 [4];
        d0[0] = 8179;  d0[1] = -998; d0[2] = 3000; d0[3] = -40000;
        d1[0] = 100;   d1[1] = -37;  d1[2] = 300;  d1[3] = -2000;
        base = rx_count;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send_model(d0[i], 2'd0);
                    send_model(d1[i], 2'd1);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_ready: got in_ready=%0b out_valid=%0b, need 0 and 1",
                                 in_ready, out_valid);
                    end
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (rx_count - base != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, need 8", rx_count - base);
        end
    endtask

    task automatic test_enable();
        int base;
        base = rx_count;
        send_model(64'sd5000, 2'd0);
        send_model(-64'sd77, 2'd1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL freeze: got in_ready=%0b out_valid=%0b, need 0 and 0",
                         in_ready, out_valid);
            end
        end
        @(posedge clk); #1 en = 1'b1;
        drain();
        checks++;
        if (rx_count - base != 2) begin
            errors++;
            $display("FAIL enable_count: got %0d results, need 2", rx_count - base);
        end
    endtask

    task automatic test_reset_flight();
        int base;
        send_model(64'sd8179, 2'd0);
        send_model(64'sd100, 2'd1);
        send_model(-64'sd998, 2'd0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'sd0 || out_ch !== 2'd0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL rst_flight: got v=%0b d=%0d ch=%0d sat=%0b, need all 0",
                     out_valid, out_data, out_ch, out_sat);
        end
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            m_mult[i] = '0; m_shift[i] = '0; m_zp[i] = '0;
        end
        @(posedge clk); #1 rst = 1'b0;
        base = rx_count;
        send(64'sd8179, 2'd0, 8'sd0, 1'b0);
        send(-(64'sd1 <<< 20), 2'd1, 8'sd0, 1'b0);
        drain();
        checks++;
        if (rx_count - base != 2) begin
            errors++;
            $display("FAIL post_rst_count: got %0d results, need 2", rx_count - base);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000ns, need completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_saturate();
        test_back_to_back();
        test_enable();
        test_reset_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
